// File: rtl/rsa_rom_pkg.sv
// Shared constants and FSM states for the RSA operand/key ROM reader.
// ROM geometry: 18-bit addresses, 6-bit words, top 4K words unpopulated.
package rsa_rom_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 6;
    localparam int DEPTH  = 2**18 - 2**12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/rom_skid_fifo.sv
// Two-entry FIFO holding ROM words plus their last tag.
// Latency: one cycle from push to visible head. Head holds until popped.
// Backpressure: no full flag; the caller's credit rule keeps it from overflowing.
module rom_skid_fifo
    import rsa_rom_pkg::*;
#(
    parameter int W = DATA_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign dout   = mem[rd_ptr];

    // When full, push and pop together write the slot being vacated by the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Walks the block ROM for a (base, len) command and emits words as a valid/ready stream.
// Latency: first word valid 3 cycles after start; 1 word/cycle sustained.
// Backpressure: issue stalls on credit; at most 2 words buffered, none lost or duplicated.
module rom_stream_reader
    import rsa_rom_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE       = (ADDR_W+1)'(1);

    state_t          state;
    logic [ADDR_W:0] remaining;
    logic            inflight;
    logic            inflight_last;
    logic [1:0]      fifo_count;
    logic [DATA_W:0] head;
    logic            pop;
    logic            credit;
    logic            issue;

    assign m_valid          = (fifo_count != 2'd0);
    assign pop              = m_valid & m_ready;
    assign {m_last, m_data} = head;

    // Words already buffered plus the one arriving from the ROM must leave room for this issue.
    assign credit = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign issue  = (state == RUN) && (remaining != '0) && credit;

    rom_skid_fifo #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   ({inflight_last, rom_data}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    // rom_addr always holds the next address; an issue commits it as the ROM samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rom_addr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done          <= 1'b0;
            err           <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (remaining == ONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        if ({1'b0, base} >= DEPTH_CNT) begin
                            err <= 1'b1;
                        end else if (len == '0) begin
                            state <= DONE;
                            busy  <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            rom_addr  <= base;
                            remaining <= (len > DEPTH_CNT) ? DEPTH_CNT : len;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        rom_addr  <= (rom_addr == LAST_ADDR) ? '0 : rom_addr + ADDR_W'(1);
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last && !inflight && (fifo_count == 2'd1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader: behavioural ROM, expected streams built
// from (base + i) mod DEPTH, randomized backpressure and command mix.
module tb_rom_stream_reader;
    import rsa_rom_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data = '0;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] obs_data [$];
    logic              obs_last [$];
    logic [ADDR_W-1:0] obs_addr [$];
    int done_cyc, first_vld, err_cyc, stab_err, max_cnt;
    int busy_seen, valid_seen, timed_out;

    always #5 clk = ~clk;

    rom_stream_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    function automatic logic [DATA_W-1:0] rom_word(input int unsigned a);
        int unsigned h;
        h = (a * 37) ^ (a >> 5) ^ 21;
        return DATA_W'(h);
    endfunction

    function automatic int wrap_addr(input int b, input int i);
        return (b + i) % DEPTH;
    endfunction

    // One-cycle registered-read ROM.
    always @(posedge clk) rom_data <= rom_word(int'(rom_addr));

    // mode 0: ready high; 1: ready 1,0,0 repeating from first valid; 2: random ready.
    task automatic run_cmd(input int b, input int l, input int mode, input int budget,
                           input int restart_at);
        obs_data.delete();
        obs_last.delete();
        obs_addr.delete();
        done_cyc = -1; first_vld = -1; err_cyc = -1; stab_err = 0; max_cnt = 0;
        busy_seen = 0; valid_seen = 0; timed_out = 0;
        @(negedge clk);
        start = 1'b1;
        base  = ADDR_W'(b);
        len   = (ADDR_W+1)'(l);
        @(negedge clk);
        start = 1'b0;
        begin
            logic              prev_stall;
            logic [DATA_W-1:0] prev_d;
            logic              prev_l;
            prev_stall = 1'b0;
            prev_d     = '0;
            prev_l     = 1'b0;
            for (int cyc = 1; cyc <= budget; cyc++) begin
                if (cyc == restart_at) begin
                    start = 1'b1;
                    base  = ADDR_W'(32'h100);
                    len   = (ADDR_W+1)'(2);
                end else begin
                    start = 1'b0;
                end
                case (mode)
                    0:       m_ready = 1'b1;
                    1:       m_ready = (cyc % 3 == 0);
                    default: m_ready = 1'($urandom_range(0, 1));
                endcase
                if (m_valid) begin
                    valid_seen = 1;
                    if (first_vld < 0) first_vld = cyc;
                end
                if (busy) busy_seen = 1;
                if (err && err_cyc < 0) err_cyc = cyc;
                if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
                if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l))
                    stab_err++;
                prev_stall = m_valid && !m_ready;
                prev_d     = m_data;
                prev_l     = m_last;
                obs_addr.push_back(rom_addr);
                if (m_valid && m_ready) begin
                    obs_data.push_back(m_data);
                    obs_last.push_back(m_last);
                end
                if (done) begin
                    done_cyc = cyc;
                    break;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (done_cyc < 0) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", err); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", m_valid); end
        n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b expected 0", m_last); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", m_data); end
        n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", rom_addr); end
        rst = 1'b0;
    endtask

    task automatic test_basic_burst();
        run_cmd(32'h10, 4, 0, 30, 0);
        n_checks++; if (obs_data.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", obs_data.size()); end
        for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== rom_word(32'h10 + i) || obs_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL basic_word%0d: got %0h/%0b expected %0h/%0b", i, obs_data[i], obs_last[i], rom_word(32'h10 + i), (i == 3));
            end
        end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            n_checks++;
            if (int'(obs_addr[i]) != 32'h10 + i) begin n_fail++; $display("FAIL basic_addr%0d: got %0h expected %0h", i, obs_addr[i], 32'h10 + i); end
        end
        n_checks++; if (first_vld != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", first_vld); end
        n_checks++; if (done_cyc != 7) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 7", done_cyc); end
    endtask

    task automatic test_backpressure();
        run_cmd(32'h200, 8, 1, 80, 0);
        n_checks++; if (obs_data.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", obs_data.size()); end
        for (int i = 0; i < 8 && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== rom_word(32'h200 + i) || obs_last[i] !== (i == 7)) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %0h/%0b expected %0h/%0b", i, obs_data[i], obs_last[i], rom_word(32'h200 + i), (i == 7));
            end
        end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stab_err); end
        n_checks++; if (max_cnt > 2) begin n_fail++; $display("FAIL bp_fifo_max: got %0d expected <=2", max_cnt); end
        n_checks++; if (timed_out != 0) begin n_fail++; $display("FAIL bp_timeout: got %0d expected 0", timed_out); end
    endtask

    task automatic test_wrap();
        run_cmd(DEPTH - 2, 4, 0, 30, 0);
        n_checks++; if (obs_data.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", obs_data.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            n_checks++;
            if (int'(obs_addr[i]) != wrap_addr(DEPTH - 2, i)) begin
                n_fail++; $display("FAIL wrap_addr%0d: got %0h expected %0h", i, obs_addr[i], wrap_addr(DEPTH - 2, i));
            end
        end
        for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== rom_word(wrap_addr(DEPTH - 2, i)) || obs_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap_word%0d: got %0h/%0b expected %0h/%0b", i, obs_data[i], obs_last[i], rom_word(wrap_addr(DEPTH - 2, i)), (i == 3));
            end
        end
    endtask

    task automatic test_reject();
        run_cmd(DEPTH, 4, 0, 6, 0);
        n_checks++; if (err_cyc != 1) begin n_fail++; $display("FAIL reject_err_cycle: got %0d expected 1", err_cyc); end
        n_checks++; if (busy_seen != 0) begin n_fail++; $display("FAIL reject_busy: got %0d expected 0", busy_seen); end
        n_checks++; if (valid_seen != 0 || done_cyc != -1) begin n_fail++; $display("FAIL reject_activity: got valid=%0d done=%0d expected 0/-1", valid_seen, done_cyc); end
    endtask

    task automatic test_len_zero();
        run_cmd(32'h30, 0, 0, 10, 0);
        n_checks++; if (done_cyc != 1) begin n_fail++; $display("FAIL len0_done_cycle: got %0d expected 1", done_cyc); end
        n_checks++; if (valid_seen != 0) begin n_fail++; $display("FAIL len0_valid: got %0d expected 0", valid_seen); end
        n_checks++; if (busy_seen != 1) begin n_fail++; $display("FAIL len0_busy: got %0d expected 1", busy_seen); end
    endtask

    task automatic test_start_ignored();
        run_cmd(32'h400, 6, 0, 40, 3);
        n_checks++; if (obs_data.size() != 6) begin n_fail++; $display("FAIL ignore_count: got %0d expected 6", obs_data.size()); end
        for (int i = 0; i < 6 && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== rom_word(32'h400 + i) || obs_last[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL ignore_word%0d: got %0h/%0b expected %0h/%0b", i, obs_data[i], obs_last[i], rom_word(32'h400 + i), (i == 5));
            end
        end
        n_checks++; if (err_cyc != -1 || done_cyc != 9) begin n_fail++; $display("FAIL ignore_err_done: got err=%0d done=%0d expected -1/9", err_cyc, done_cyc); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int b, l;
            b = (r % 2 == 1) ? DEPTH - int'($urandom_range(1, 8)) : int'($urandom_range(0, DEPTH - 1));
            l = int'($urandom_range(1, 20));
            run_cmd(b, l, 2, 60 * l + 20, 0);
            n_checks++;
            if (obs_data.size() != l || timed_out != 0) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d words timeout=%0d expected %0d/0", r, obs_data.size(), timed_out, l);
            end
            for (int i = 0; i < l && i < obs_data.size(); i++) begin
                n_checks++;
                if (obs_data[i] !== rom_word(wrap_addr(b, i)) || obs_last[i] !== (i == l - 1)) begin
                    n_fail++;
                    $display("FAIL rand%0d_word%0d: got %0h/%0b expected %0h/%0b", r, i, obs_data[i], obs_last[i], rom_word(wrap_addr(b, i)), (i == l - 1));
                end
            end
            n_checks++;
            if (stab_err != 0 || max_cnt > 2) begin
                n_fail++; $display("FAIL rand%0d_flow: got unstable=%0d fifo_max=%0d expected 0/<=2", r, stab_err, max_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int hs, c;
        @(negedge clk);
        start = 1'b1; base = ADDR_W'(32'h40); len = (ADDR_W+1)'(16); m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0; c = 0;
        while (hs < 5 && c < 60) begin
            if (m_valid && m_ready) hs++;
            @(negedge clk);
            c++;
        end
        n_checks++; if (hs != 5) begin n_fail++; $display("FAIL rstmid_handshakes: got %0d expected 5", hs); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b expected 0", m_valid); end
        n_checks++; if (dut.u_fifo.count !== 2'd0) begin n_fail++; $display("FAIL rstmid_fifo: got %0d expected 0", dut.u_fifo.count); end
        rst = 1'b0;
        run_cmd(32'h20, 2, 0, 20, 0);
        n_checks++; if (obs_data.size() != 2) begin n_fail++; $display("FAIL rstmid_after_count: got %0d expected 2", obs_data.size()); end
        for (int i = 0; i < 2 && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== rom_word(32'h20 + i) || obs_last[i] !== (i == 1)) begin
                n_fail++;
                $display("FAIL rstmid_word%0d: got %0h/%0b expected %0h/%0b", i, obs_data[i], obs_last[i], rom_word(32'h20 + i), (i == 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_wrap();
        test_reject();
        test_len_zero();
        test_start_ignored();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Reader-side companion to the 6-bit block ROM that holds the RSA operand/key image. Accepts a command (base address, word count), walks the ROM respecting its one-cycle registered read latency, and presents the words as a valid/ready stream with a last flag. Sits between the ROM and the RSA datapath front end. Backpressure never loses or duplicates a word.

## Interface
- `ADDR_W`, 18, ROM address width.
- `DATA_W`, 6, ROM word width.
- `DEPTH`, 2**18 - 2**12 (258048), number of populated ROM words. Valid addresses are 0..DEPTH-1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle command strobe.
- `base`  in  ADDR_W  first word address, sampled with `start`.
- `len`  in  ADDR_W+1  word count, sampled with `start`.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse at command completion.
- `err`  out  1  one-cycle pulse when a command is rejected.
- `rom_addr`  out  ADDR_W  address to ROM; registered output.
- `rom_data`  in  DATA_W  ROM read data, valid one cycle after `rom_addr` is presented.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_W  stream word.
- `m_last`  out  1  marks the final word of the command.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start=1` with `base>=DEPTH`: pulse `err` next cycle and stay in IDLE.
  - `start=1` with `len=0`: go to DONE with no words emitted.
  - Otherwise latch `base`, set remaining-issue count to min(`len`, DEPTH), and go to RUN.
- **`start` while not in IDLE**: ignored. No `err`, no effect.
- **RUN**
  - Issue one address per cycle while credit is available. Issue means driving `rom_addr` to the current address and setting `inflight` for the next cycle.
  - Credit condition: fifo_count + inflight − pop < 2, where pop = `m_valid & m_ready`.
  - Address increments by 1. Address DEPTH−1 wraps to 0.
  - After the last issue, go to DRAIN.
- **`inflight`**: 1-bit register. When set, `rom_data` is written into a 2-entry FIFO that cycle. Each written word carries a last tag, set when it is the final word of the command.
- **DRAIN**: wait until `inflight=0`, the FIFO is empty, and the last word has been handshaken; then go to DONE.
- **DONE**: pulse `done` for one cycle, then go to IDLE.
- **Stream output**: `m_data`/`m_last` come from the FIFO head; `m_valid` = FIFO not empty.
  - Once `m_valid` is high, `m_data` and `m_last` hold stable until the handshake.
- **FIFO**: never overflows (guaranteed by the credit rule). Simultaneous push and pop is legal at any occupancy.
- **`busy`**: 1 in RUN, DRAIN and DONE; 0 in IDLE.
- **Reset at any time**: state goes to IDLE, the FIFO is emptied, `inflight` is cleared, and any ROM data in transit is discarded.
- **Reset values**: `busy`=0, `done`=0, `err`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `rom_addr`=0.

## Timing
- Edge E0 samples `start`.
- `rom_addr`=`base` after E0.
- ROM registers the address at E1; FIFO captures the word at E2.
- `m_valid`=1 after E2, i.e. first-word latency is 3 cycles.
- With `m_ready` held high: sustained throughput is 1 word/cycle, and an N-word command completes with `done` asserted N+3 cycles after E0.
- `done` asserts the cycle after the handshake of the `m_last` word.
- `len=0`: `done` asserts the cycle after E0.
- `err` asserts the cycle after E0.
- `m_ready` low: issue stalls within 1 cycle, and at most 2 words are buffered. Resuming `m_ready` gives no bubbles beyond the 2-cycle ROM refill.

## Structure
- Shared package `rsa_rom_pkg` holds:
  - the ADDR_W, DATA_W and DEPTH constants;
  - the state enum (IDLE, RUN, DRAIN, DONE).
- One natural sub-module: `rom_skid_fifo`, a 2-entry FIFO of DATA_W+1 bits with synchronous `rst`, push/pop, and a count output.
- Top level contains the FSM, the address/count registers, `inflight` and the credit logic.

## Test plan
- **Basic burst**: reset, then `start`, `base=0x00010`, `len=4`, `m_ready=1` → `rom_addr` steps 0x10..0x13; `m_data` = mem[0x10..0x13] on consecutive cycles; `m_last` on the 4th; `done` at E0+7.
- **Backpressure**: `len=8`, `m_ready` toggles 1,0,0,1,… → all 8 words delivered in order with none duplicated; data stable while stalled; FIFO count never exceeds 2.
- **Wrap-around**: `base=DEPTH-2`, `len=4` → addresses DEPTH−2, DEPTH−1, 0, 1; `m_last` on address 1.
- **Rejects and zero length**:
  - `base=DEPTH` → `err` pulse, `busy` stays 0.
  - `len=0` → `done` at E0+1, no `m_valid`.
  - `start` mid-burst → ignored, burst unaltered.
- **Reset mid-operation**: `len=16`, assert `rst` after the 5th handshake → next cycle `busy`=0, `m_valid`=0, FIFO empty. A following `start`, `base=0x20`, `len=2` streams mem[0x20], mem[0x21] correctly.
